seq_det_sched: RTL and testbench
================================

Name: seq_det_sched

Overview:
- Round-robin scheduler that shares one serial pattern-detection engine among NREQ requesters.
- Each requester presents a WIDTH-bit word. The block grants one requester, latches its word and shifts it LSB-first through the built-in overlapping pattern matcher.
- It reports per-bit hits and a final match count with a done pulse, then moves on to the next requester.
- Sits between the parallel capture registers and the result/status logic of the detector subsystem.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 9, bits per word, shifted word[0] first
- PAT_LEN, 4, pattern length in bits (2..WIDTH)
- PAT, 4'b1011, pattern; PAT[PAT_LEN-1] is the first bit to arrive, so the default detects arrival order 1,0,1,1
- CW, $clog2(WIDTH+1), match counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req  in  NREQ  per-requester request level
- data  in  NREQ*WIDTH  requester i word at data[i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant pulse, one cycle
- busy  out  1  high from grant cycle through done cycle
- ser_valid  out  1  high while a bit is being scanned
- ser_bit  out  1  bit currently scanned
- hit  out  1  pattern completed on the current bit
- done  out  1  one-cycle end-of-word pulse
- done_id  out  $clog2(NREQ)  requester just finished; valid with done
- match_cnt  out  CW  number of hits in the finished word; valid with done, held until next done

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high; sampled only on posedge clk.
- Reset state:
  - FSM=IDLE, rr pointer=0, shift counter=0, window=0.
  - gnt, busy, ser_valid, ser_bit, hit and done are 0; done_id=0; match_cnt=0.
- FSM states: IDLE, GRANT, SHIFT, REPORT.
- IDLE:
  - If req!=0, select the first set req starting at the rr pointer, wrapping modulo NREQ, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (cycle T):
  - gnt[i]=1 and busy=1.
  - Latch data word i.
  - Clear window, bit counter and running count.
  - rr pointer <= (i+1) mod NREQ.
  - Go to SHIFT.
- SHIFT (cycles T+1 .. T+WIDTH):
  - ser_valid=1 and ser_bit=word[k] at cycle T+1+k.
  - The window shifts in each bit.
  - hit=1 at cycle T+1+k iff k>=PAT_LEN-1 and bits k-PAT_LEN+1..k equal PAT in arrival order.
  - Matching overlaps: the window is not cleared on a hit.
  - The running count increments on each hit and saturates at 2^CW-1.
  - After bit WIDTH-1, go to REPORT.
- REPORT (cycle T+WIDTH+1):
  - done=1, done_id=i, match_cnt=final count, busy=1.
  - Go to IDLE.
  - The earliest next gnt is T+WIDTH+2.
- All outputs are registered.
- Requests:
  - req changes while busy are ignored; only the latched word is scanned.
  - A requester deasserts req after its done; a still-asserted req is re-granted only after its round-robin turn comes back.
- No matches across words: the window and counter are cleared at every GRANT.
- Simultaneous requests: resolved purely by the rr pointer; exactly one gnt bit is ever high.
- rst in any state, including mid-SHIFT:
  - The next cycle is IDLE with reset values.
  - The partial word is discarded with no done.
  - The rr pointer returns to 0.

Optional Feature:
- Macro SEQ_DET_SCHED_PRIO_EN.
- Defined: fixed priority, lowest-index set req wins; the rr pointer is neither used nor updated.
- Undefined: round-robin arbitration as described in Behaviour.
- Timing, FSM and the matcher are identical in both builds.

Test Plan:
- Single word, count 1:
  - Stimulus: req=4'b0001, data[0]=9'b011010110.
  - Required: gnt=4'b0001 at T; ser_bit sequence 0,1,1,0,1,0,1,1,0.
  - Required: hit only at T+8; done at T+10 with done_id=0 and match_cnt=1.
- Overlapping matches:
  - Stimulus: data[1]=9'b001101101, req=4'b0010.
  - Required: hits at T+4 and T+7; done with done_id=1 and match_cnt=2.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held.
  - Required: grant order 0,1,2,3,0, with consecutive gnt pulses WIDTH+2=11 cycles apart.
  - Required under SEQ_DET_SCHED_PRIO_EN: 0,0,0.
- No match:
  - Stimulus: data[2]=9'h000, req=4'b0100.
  - Required: no hit; done with done_id=2 and match_cnt=0.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle at T+5 during a scan.
  - Required: next cycle busy, ser_valid and done are 0; no done for that word.
  - Required: the next grant with req=4'b1111 goes to requester 0.
- Request change during scan:
  - Stimulus: change data[0] and drop req[0] at T+3.
  - Required: the scan completes with the originally latched word; done_id=0 and match_cnt unchanged.

Source files
------------

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial overlapping pattern matcher among NREQ requesters.
// Build macro SEQ_DET_SCHED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module seq_det_sched #(
    parameter int unsigned        NREQ    = 4,
    parameter int unsigned        WIDTH   = 9,
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PAT     = 4'b1011,
    parameter int unsigned        CW      = $clog2(WIDTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    ser_valid,
    output logic                    ser_bit,
    output logic                    hit,
    output logic                    done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [CW-1:0]           match_cnt
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned KW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SHIFT, S_REPORT} state_t;

    state_t             r_state, w_state_nxt;
    logic [NREQ-1:0]    r_gnt, w_gnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_ser_valid, w_ser_valid_nxt;
    logic               r_ser_bit, w_ser_bit_nxt;
    logic               r_hit, w_hit_nxt;
    logic               r_done, w_done_nxt;
    logic [IW-1:0]      r_done_id, w_done_id_nxt;
    logic [CW-1:0]      r_match_cnt, w_match_cnt_nxt;
    logic [IW-1:0]      r_idx, w_idx_nxt;
    logic [WIDTH-1:0]   r_word, w_word_nxt;
    logic [PAT_LEN-1:0] r_win, w_win_nxt;
    logic [KW-1:0]      r_k, w_k_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;

    logic [WIDTH-1:0]   w_words [NREQ];
    logic [IW-1:0]      w_base, w_cand, w_sel;
    logic               w_sel_found;
    logic               w_bit;
    logic [KW-1:0]      w_kbit;
    logic [PAT_LEN-1:0] w_win_sh;
    logic               w_hit_now;

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign w_words[g] = data[g*WIDTH +: WIDTH];
    end

`ifdef SEQ_DET_SCHED_PRIO_EN
    assign w_base = '0;
`else
    logic [IW-1:0] r_rr, w_rr_nxt;
    assign w_base = r_rr;
`endif

    // First set request at or after the search base, wrapping modulo NREQ
    always_comb begin
        w_sel_found = 1'b0;
        w_sel       = '0;
        w_cand      = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            w_cand = IW'((32'(w_base) + j) % NREQ);
            if (!w_sel_found && req[w_cand]) begin
                w_sel_found = 1'b1;
                w_sel       = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = '0;
        w_busy_nxt      = r_busy;
        w_ser_valid_nxt = 1'b0;
        w_ser_bit_nxt   = 1'b0;
        w_hit_nxt       = 1'b0;
        w_done_nxt      = 1'b0;
        w_done_id_nxt   = r_done_id;
        w_match_cnt_nxt = r_match_cnt;
        w_idx_nxt       = r_idx;
        w_word_nxt      = r_word;
        w_win_nxt       = r_win;
        w_k_nxt         = r_k;
        w_cnt_nxt       = r_cnt;
`ifndef SEQ_DET_SCHED_PRIO_EN
        w_rr_nxt        = r_rr;
`endif
        // Bit k presented next: word[0] straight from the requester in GRANT, else the shifted copy
        w_bit     = (r_state == S_GRANT) ? w_words[r_idx][0] : r_word[0];
        w_kbit    = (r_state == S_GRANT) ? '0 : KW'(r_k + KW'(1));
        w_win_sh  = {r_win[PAT_LEN-2:0], w_bit};
        w_hit_now = (32'(w_kbit) >= PAT_LEN - 1) && (w_win_sh == PAT);

        case (r_state)
            S_IDLE, S_REPORT: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
                if (w_sel_found) begin
                    w_state_nxt      = S_GRANT;
                    w_gnt_nxt[w_sel] = 1'b1;
                    w_busy_nxt       = 1'b1;
                    w_idx_nxt        = w_sel;
                    w_win_nxt        = '0;
                    w_k_nxt          = '0;
                    w_cnt_nxt        = '0;
`ifndef SEQ_DET_SCHED_PRIO_EN
                    w_rr_nxt = (32'(w_sel) == NREQ - 1) ? '0 : IW'(w_sel + IW'(1));
`endif
                end
            end
            S_GRANT, S_SHIFT: begin
                if (r_state == S_SHIFT && 32'(r_k) == WIDTH - 1) begin
                    w_state_nxt     = S_REPORT;
                    w_done_nxt      = 1'b1;
                    w_done_id_nxt   = r_idx;
                    w_match_cnt_nxt = r_cnt;
                end else begin
                    w_state_nxt     = S_SHIFT;
                    w_ser_valid_nxt = 1'b1;
                    w_ser_bit_nxt   = w_bit;
                    w_hit_nxt       = w_hit_now;
                    w_win_nxt       = w_win_sh;
                    w_k_nxt         = w_kbit;
                    w_word_nxt      = (r_state == S_GRANT) ? (w_words[r_idx] >> 1) : (r_word >> 1);
                    if (w_hit_now && r_cnt != '1) begin
                        w_cnt_nxt = CW'(r_cnt + CW'(1));
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt       <= '0;
            r_busy      <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_bit   <= 1'b0;
            r_hit       <= 1'b0;
            r_done      <= 1'b0;
            r_done_id   <= '0;
            r_match_cnt <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_win       <= '0;
            r_k         <= '0;
            r_cnt       <= '0;
`ifndef SEQ_DET_SCHED_PRIO_EN
            r_rr        <= '0;
`endif
        end else begin
            r_gnt       <= w_gnt_nxt;
            r_busy      <= w_busy_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_ser_bit   <= w_ser_bit_nxt;
            r_hit       <= w_hit_nxt;
            r_done      <= w_done_nxt;
            r_done_id   <= w_done_id_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_word      <= w_word_nxt;
            r_win       <= w_win_nxt;
            r_k         <= w_k_nxt;
            r_cnt       <= w_cnt_nxt;
`ifndef SEQ_DET_SCHED_PRIO_EN
            r_rr        <= w_rr_nxt;
`endif
        end
    end

    assign gnt       = r_gnt;
    assign busy      = r_busy;
    assign ser_valid = r_ser_valid;
    assign ser_bit   = r_ser_bit;
    assign hit       = r_hit;
    assign done      = r_done;
    assign done_id   = r_done_id;
    assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: stimulus queues expected grants, hit offsets and done
// results; a negedge monitor pops and compares them as the DUT presents each event.
`timescale 1ns/1ps
module tb_seq_det_sched;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 9;
    localparam int unsigned CW    = 4;
    localparam int          RPT   = WIDTH + 1;
    localparam int          GAP   = WIDTH + 2;

    localparam logic [WIDTH-1:0] W0 = 9'b011010110;  // hit at bit 7
    localparam logic [WIDTH-1:0] W1 = 9'b001101101;  // hits at bits 3 and 6
    localparam logic [WIDTH-1:0] W3 = 9'b110100000;  // hit on the last bit

    typedef struct { int id; int gap; } gnt_exp_t;
    typedef struct { int id; int cnt; logic [WIDTH-1:0] word; } done_exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   data;
    logic [NREQ-1:0]         gnt;
    logic                    busy;
    logic                    ser_valid;
    logic                    ser_bit;
    logic                    hit;
    logic                    done;
    logic [1:0]              done_id;
    logic [CW-1:0]           match_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    gnt_exp_t  exp_gnt[$];
    int        exp_hit[$];
    done_exp_t exp_done[$];

    gnt_exp_t         mg;
    done_exp_t        md;
    int               t_gnt = 0;
    logic [WIDTH-1:0] cap   = '0;
    int               nbits = 0;

    seq_det_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .busy      (busy),
        .ser_valid (ser_valid),
        .ser_bit   (ser_bit),
        .hit       (hit),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every grant, hit and done must match the next queued expectation
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (gnt !== '0) begin
                if (exp_gnt.size() == 0) begin
                    chk("gnt_unexpected", int'(gnt), 0);
                end else begin
                    mg = exp_gnt.pop_front();
                    chk("gnt_onehot", int'(gnt), 1 << mg.id);
                    chk("gnt_busy", int'(busy), 1);
                    if (mg.gap >= 0) chk("gnt_gap", cyc - t_gnt, mg.gap);
                end
                t_gnt = cyc;
                cap   = '0;
                nbits = 0;
            end
            if (ser_valid === 1'b1) begin
                if (nbits < WIDTH) cap[nbits] = ser_bit;
                nbits++;
            end
            if (hit === 1'b1) begin
                if (exp_hit.size() == 0) chk("hit_unexpected", int'(hit), 0);
                else                     chk("hit_offset", cyc - t_gnt, exp_hit.pop_front());
            end
            if (done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    chk("done_unexpected", int'(done), 0);
                end else begin
                    md = exp_done.pop_front();
                    chk("done_id", int'(done_id), md.id);
                    chk("match_cnt", int'(match_cnt), md.cnt);
                    chk("ser_word", int'(cap), int'(md.word));
                    chk("ser_bits", nbits, WIDTH);
                    chk("done_offset", cyc - t_gnt, RPT);
                    chk("done_busy", int'(busy), 1);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [WIDTH-1:0] w);
        data[i*WIDTH +: WIDTH] = w;
    endtask

    task automatic push_gnt(input int id, input int gap);
        gnt_exp_t g;
        g.id  = id;
        g.gap = gap;
        exp_gnt.push_back(g);
    endtask

    task automatic push_done(input int id, input int cnt, input logic [WIDTH-1:0] w);
        done_exp_t d;
        d.id   = id;
        d.cnt  = cnt;
        d.word = w;
        exp_done.push_back(d);
    endtask

    task automatic wait_gnt(input string name);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (gnt != '0) return;
        end
        chk({name, "_gnt_timeout"}, 1, 0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            tick();
            if (exp_done.size() == 0 && exp_gnt.size() == 0) begin
                tick(2);
                return;
            end
        end
        chk({name, "_drain_timeout"}, 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = '0;
        data = '0;
        tick(3);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ser_valid", int'(ser_valid), 0);
        chk("rst_ser_bit", int'(ser_bit), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_id", int'(done_id), 0);
        chk("rst_match_cnt", int'(match_cnt), 0);
        rst = 1'b0;
        tick(2);

        // Single word, one hit
        set_word(0, W0);
        push_gnt(0, -1); exp_hit.push_back(8); push_done(0, 1, W0);
        req = 4'b0001;
        wait_gnt("single");
        req = '0;
        wait_drain("single");

        // Overlapping matches
        set_word(1, W1);
        push_gnt(1, -1); exp_hit.push_back(4); exp_hit.push_back(7); push_done(1, 2, W1);
        req = 4'b0010;
        wait_gnt("overlap");
        req = '0;
        wait_drain("overlap");

        // No match
        set_word(2, '0);
        push_gnt(2, -1); push_done(2, 0, '0);
        req = 4'b0100;
        wait_gnt("nomatch");
        req = '0;
        wait_drain("nomatch");

        // Word and request change mid-scan must not disturb the latched word
        set_word(0, W0);
        push_gnt(0, -1); exp_hit.push_back(8); push_done(0, 1, W0);
        req = 4'b0001;
        wait_gnt("change");
        tick(3);
        set_word(0, 9'h1FF);
        req = '0;
        wait_drain("change");

        // Reset mid-scan: no done for the partial word, pointer back to 0
        set_word(2, W3);
        push_gnt(2, -1);
        req = 4'b0100;
        wait_gnt("reset");
        req = '0;
        tick(5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("postrst_busy", int'(busy), 0);
        chk("postrst_ser_valid", int'(ser_valid), 0);
        chk("postrst_done", int'(done), 0);
        chk("postrst_gnt", int'(gnt), 0);
        chk("postrst_match_cnt", int'(match_cnt), 0);

        // Fairness with all requests held
        set_word(0, W0);
        set_word(1, W1);
        set_word(2, '0);
        set_word(3, W3);
`ifdef SEQ_DET_SCHED_PRIO_EN
        for (int k = 0; k < 3; k++) begin
            push_gnt(0, (k == 0) ? -1 : GAP); exp_hit.push_back(8); push_done(0, 1, W0);
        end
`else
        push_gnt(0, -1);  exp_hit.push_back(8); push_done(0, 1, W0);
        push_gnt(1, GAP); exp_hit.push_back(4); exp_hit.push_back(7); push_done(1, 2, W1);
        push_gnt(2, GAP); push_done(2, 0, '0);
        push_gnt(3, GAP); exp_hit.push_back(9); push_done(3, 1, W3);
        push_gnt(0, GAP); exp_hit.push_back(8); push_done(0, 1, W0);
`endif
        req = 4'b1111;
        for (int i = 0; i < 100 && exp_gnt.size() != 0; i++) tick();
        req = '0;
        wait_drain("fair");

        tick(5);
        chk("left_gnt", exp_gnt.size(), 0);
        chk("left_hit", exp_hit.size(), 0);
        chk("left_done", exp_done.size(), 0);
        chk("final_idle_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
